// File: rtl/vga_value_display.sv
// rtl/vga_value_display.sv - VGA text overlay showing NUM_CH data channels as binary/hex digit rows
// Optional feature macro: VGA_CHANGE_HL_EN (per-channel change highlighting)
`ifndef log2NUM_COLS
`define log2NUM_COLS 10
`endif
`ifndef log2NUM_ROWS
`define log2NUM_ROWS 10
`endif

module vga_value_display #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 8,
  parameter int ROW0        = 2,
  parameter int TEXT_X      = 128,
  parameter int HOLD_FRAMES = 60
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic                       hex_mode,
  input  logic [`log2NUM_COLS-1:0]   XPos,
  input  logic [`log2NUM_ROWS-1:0]   YPos,
  input  logic                       Valid,
  output logic [5:0]                 vga_rgb
);

  localparam int XW  = `log2NUM_COLS;
  localparam int YW  = `log2NUM_ROWS;
  localparam int NIB = (DATA_W + 3) / 4;

  localparam logic [5:0] COL_LABEL = 6'b001100;
  localparam logic [5:0] COL_DIGIT = 6'b111111;
  localparam logic [5:0] COL_HL    = 6'b111100;

  // Subset of the 6-bit-coded character ROM: only the glyphs this overlay can emit.
  function automatic logic [7:0] glyph_row(input logic [5:0] code, input logic [2:0] line);
    logic [63:0] g;
    case (code)
      6'd1:    g = 64'h183C667E66666600;  // A
      6'd2:    g = 64'h7C66667C66667C00;  // B
      6'd3:    g = 64'h3C66606060663C00;  // C
      6'd4:    g = 64'h786C6666666C7800;  // D
      6'd5:    g = 64'h7E60607860607E00;  // E
      6'd6:    g = 64'h7E60607860606000;  // F
      6'd8:    g = 64'h6666667E66666600;  // H
      6'd48:   g = 64'h3C666E7666663C00;  // 0
      6'd49:   g = 64'h1818381818187E00;  // 1
      6'd50:   g = 64'h3C66060C30607E00;  // 2
      6'd51:   g = 64'h3C66061C06663C00;  // 3
      6'd52:   g = 64'h060E1E667F060600;  // 4
      6'd53:   g = 64'h7E607C0606663C00;  // 5
      6'd54:   g = 64'h3C66607C66663C00;  // 6
      6'd55:   g = 64'h7E660C1818181800;  // 7
      6'd56:   g = 64'h3C66663C66663C00;  // 8
      6'd57:   g = 64'h3C66663E06663C00;  // 9
      default: g = 64'h0;                 // space and everything unused
    endcase
    return 8'(g >> (8 * (7 - int'(line))));
  endfunction

  // Frame-start detection and frame-synchronous shadow state
  logic                at_origin;
  logic                at_origin_q;
  logic                fs;
  logic                mode_q;
  logic [DATA_W-1:0]   shadow [NUM_CH];
  logic [NUM_CH-1:0]   hl;

  assign at_origin = Valid && (XPos == '0) && (YPos == '0);
  assign fs        = at_origin && !at_origin_q;

  // Remember whether the previous cycle sat on the origin so a stalled raster gives one fs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) at_origin_q <= 1'b0;
    else          at_origin_q <= at_origin;
  end

  // Capture channel data and display mode once per frame so a frame never mixes values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else if (fs) begin
      mode_q <= hex_mode;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= ch_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef VGA_CHANGE_HL_EN
  logic [7:0] hl_cnt [NUM_CH];

  // Per-channel hold counter: reload on a changed capture, otherwise count frames down to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) hl_cnt[i] <= '0;
    end else if (fs) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_data[i*DATA_W +: DATA_W] != shadow[i]) hl_cnt[i] <= 8'(HOLD_FRAMES);
        else if (hl_cnt[i] != '0)                     hl_cnt[i] <= hl_cnt[i] - 8'd1;
      end
    end
  end

  // A channel is highlighted while its counter is running
  always_comb begin
    hl = '0;
    for (int i = 0; i < NUM_CH; i++) hl[i] = (hl_cnt[i] != '0);
  end
`else
  logic unused_hold;
  assign unused_hold = ^8'(HOLD_FRAMES);
  assign hl          = '0;
`endif

  // Stage 0: map the raster position to a character code and cell colour
  logic [XW-6:0]       cell_x;
  int                  col;
  int                  row;
  int                  ch;
  logic                hit;
  logic                sel_hl;
  logic [DATA_W-1:0]   sel_data;
  logic [NIB*4-1:0]    pad;
  logic [3:0]          nib;
  logic                bit_val;
  logic [5:0]          char_code;
  logic [5:0]          colour;

  assign cell_x = (XW-5)'((XPos - XW'(TEXT_X)) >> 5);

  // Layout decode: label cells, then binary bits or hex nibbles MSB first, else space
  always_comb begin
    col       = int'(cell_x);
    row       = int'(YPos[YW-1:5]);
    hit       = 1'b0;
    ch        = 0;
    sel_data  = '0;
    sel_hl    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (row == ROW0 + 2*i) begin
        hit      = 1'b1;
        ch       = i;
        sel_data = shadow[i];
        sel_hl   = hl[i];
      end
    end
    pad              = '0;
    pad[DATA_W-1:0]  = sel_data;
    nib              = 4'(pad >> (4 * (NIB - 1 - (col - 4))));
    bit_val          = |(sel_data & (DATA_W'(1) << (DATA_W - 1 - (col - 4))));
    char_code        = 6'd32;
    colour           = '0;
    if (hit) begin
      if (col == 0) begin
        char_code = 6'd3;
        colour    = COL_LABEL;
      end else if (col == 1) begin
        char_code = 6'd8;
        colour    = COL_LABEL;
      end else if (col == 2) begin
        char_code = 6'(48 + ch);
        colour    = COL_LABEL;
      end else if (!mode_q && col >= 4 && col < 4 + DATA_W) begin
        char_code = {5'b11000, bit_val};
        colour    = sel_hl ? COL_HL : COL_DIGIT;
      end else if (mode_q && col >= 4 && col < 4 + NIB) begin
        char_code = (nib < 4'd10) ? 6'd48 + {2'b00, nib} : {2'b00, nib} - 6'd9;
        colour    = sel_hl ? COL_HL : COL_DIGIT;
      end
    end
  end

  // Two-stage pixel pipeline: stage 1 holds the ROM address, stage 2 the fetched glyph row
  logic [8:0] s1_addr;
  logic [5:0] s1_colour;
  logic [2:0] s1_xb;
  logic       s1_valid;
  logic [7:0] s2_data;
  logic [5:0] s2_colour;
  logic [2:0] s2_bit;
  logic       s2_valid;

  // Pipeline registers, cleared on reset so no stale glyph bits escape
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_addr   <= '0;
      s1_colour <= '0;
      s1_xb     <= '0;
      s1_valid  <= 1'b0;
      s2_data   <= '0;
      s2_colour <= '0;
      s2_bit    <= '0;
      s2_valid  <= 1'b0;
    end else begin
      s1_addr   <= {char_code, YPos[4:2]};
      s1_colour <= colour;
      s1_xb     <= XPos[4:2];
      s1_valid  <= Valid;
      s2_data   <= glyph_row(s1_addr[8:3], s1_addr[2:0]);
      s2_colour <= s1_colour;
      s2_bit    <= 3'd7 - s1_xb;
      s2_valid  <= s1_valid;
    end
  end

  assign vga_rgb = (s2_valid && s2_data[s2_bit]) ? s2_colour : 6'b000000;

endmodule

// File: tb/tb_vga_value_display.sv
// tb/tb_vga_value_display.sv - directed self-checking bench for vga_value_display
`ifndef log2NUM_COLS
`define log2NUM_COLS 10
`endif
`ifndef log2NUM_ROWS
`define log2NUM_ROWS 10
`endif

module tb_vga_value_display;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int ROW0   = 2;
  localparam int TEXT_X = 128;
  localparam int HOLD   = 3;

  localparam logic [5:0] LABEL = 6'b001100;
  localparam logic [5:0] DIGIT = 6'b111111;
`ifdef VGA_CHANGE_HL_EN
  localparam logic [5:0] HLC   = 6'b111100;
`else
  localparam logic [5:0] HLC   = 6'b111111;
`endif

  logic                          clk = 1'b0;
  logic                          reset_n;
  logic [NUM_CH*DATA_W-1:0]      ch_data;
  logic                          hex_mode;
  logic [`log2NUM_COLS-1:0]      x_pos;
  logic [`log2NUM_ROWS-1:0]      y_pos;
  logic                          valid;
  logic [5:0]                    vga_rgb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_value_display #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ROW0(ROW0), .TEXT_X(TEXT_X), .HOLD_FRAMES(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ch_data(ch_data), .hex_mode(hex_mode),
    .XPos(x_pos), .YPos(y_pos), .Valid(valid), .vga_rgb(vga_rgb)
  );

  // Reference glyph table (character ROM contents)
  function automatic logic [7:0] font(input int code, input int line);
    logic [63:0] g;
    case (code)
      1:  g = 64'h183C667E66666600;
      2:  g = 64'h7C66667C66667C00;
      3:  g = 64'h3C66606060663C00;
      4:  g = 64'h786C6666666C7800;
      5:  g = 64'h7E60607860607E00;
      6:  g = 64'h7E60607860606000;
      8:  g = 64'h6666667E66666600;
      48: g = 64'h3C666E7666663C00;
      49: g = 64'h1818381818187E00;
      50: g = 64'h3C66060C30607E00;
      51: g = 64'h3C66061C06663C00;
      52: g = 64'h060E1E667F060600;
      53: g = 64'h7E607C0606663C00;
      54: g = 64'h3C66607C66663C00;
      55: g = 64'h7E660C1818181800;
      56: g = 64'h3C66663C66663C00;
      57: g = 64'h3C66663E06663C00;
      default: g = 64'h0;
    endcase
    return 8'(g >> (8 * (7 - line)));
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int x, input int y, input logic v);
    x_pos = 10'(x);
    y_pos = 10'(y);
    valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      drive(0, 0, 1'b1);
      drive(3, 0, 1'b0);
    end
  endtask

  // Stream the 8 glyph columns of each glyph line of a cell; output lags input by one drive call
  task automatic check_cell(input string tag, input int row, input int col, input int code,
                            input logic [5:0] colour);
    logic [47:0] obs;
    logic [47:0] exp;
    logic [7:0]  f;
    int          y;
    for (int gr = 0; gr < 8; gr++) begin
      y   = row * 32 + gr * 4 + (gr % 4);
      obs = '0;
      exp = '0;
      for (int b = 0; b < 8; b++) begin
        drive(TEXT_X + col * 32 + 4 * b + (b % 4), y, 1'b1);
        if (b > 0) obs[47 - 6 * (b - 1) -: 6] = vga_rgb;
      end
      drive(2, 1, 1'b0);
      obs[5:0] = vga_rgb;
      f = font(code, gr);
      for (int b = 0; b < 8; b++) exp[47 - 6 * b -: 6] = f[7 - b] ? colour : 6'b0;
      check($sformatf("%s g%0d", tag, gr), 64'(obs), 64'(exp));
    end
  endtask

  task automatic check_bin(input string tag, input int row, input logic [7:0] value,
                           input logic [5:0] colour);
    for (int k = 0; k < 8; k++)
      check_cell($sformatf("%s c%0d", tag, 4 + k), row, 4 + k, value[7 - k] ? 49 : 48, colour);
  endtask

  initial begin
    reset_n  = 1'b0;
    ch_data  = '0;
    hex_mode = 1'b0;
    x_pos    = '0;
    y_pos    = '0;
    valid    = 1'b0;

    // Lit pixel of 'C' during reset must stay dark
    drive(TEXT_X + 8, ROW0 * 32, 1'b1);
    drive(TEXT_X + 8, ROW0 * 32, 1'b1);
    check("reset rgb", 64'(vga_rgb), 64'(0));
    reset_n = 1'b1;

    // Before any fs: zero shadow in binary
    ch_data = 32'h0000_00FF;
    check_cell("init C", ROW0, 0, 3, LABEL);
    check_cell("init d0", ROW0, 4, 48, DIGIT);

    // Binary rendering of 0xA5 on channel 0
    ch_data = 32'h0000_00A5;
    frames(4);
    check_cell("bin C", ROW0, 0, 3, LABEL);
    check_cell("bin H", ROW0, 1, 8, LABEL);
    check_cell("bin idx", ROW0, 2, 48, LABEL);
    check_cell("bin gap", ROW0, 3, 32, DIGIT);
    check_bin("bin A5", ROW0, 8'hA5, DIGIT);
    check_cell("bin tail", ROW0, 12, 32, DIGIT);
    check_cell("ch1 idx", ROW0 + 2, 2, 49, LABEL);

    // Hex rendering
    ch_data  = 32'h0012_3CA5;
    hex_mode = 1'b1;
    frames(4);
    check_cell("hex ch1 hi", ROW0 + 2, 4, 51, DIGIT);
    check_cell("hex ch1 lo", ROW0 + 2, 5, 3, DIGIT);
    check_cell("hex ch1 blank", ROW0 + 2, 6, 32, DIGIT);
    check_cell("hex ch0 hi", ROW0, 4, 1, DIGIT);
    check_cell("hex ch0 lo", ROW0, 5, 53, DIGIT);
    check_cell("hex ch2 hi", ROW0 + 4, 4, 49, DIGIT);

    // Mid-frame change is invisible until the next fs
    ch_data  = 32'h009F_3CA5;
    hex_mode = 1'b0;
    check_cell("mid ch2 hi", ROW0 + 4, 4, 49, DIGIT);
    check_cell("mid ch2 lo", ROW0 + 4, 5, 50, DIGIT);
    check_cell("mid ch2 c6", ROW0 + 4, 6, 32, DIGIT);
    frames(1);
    check_bin("new ch2 f1", ROW0 + 4, 8'h9F, HLC);
    check_cell("new ch0 f1", ROW0, 4, 49, DIGIT);
    frames(1);
    check_cell("hl ch2 f2", ROW0 + 4, 4, 49, HLC);
    check_cell("hl ch1 f2", ROW0 + 2, 6, 49, DIGIT);
    frames(1);
    check_cell("hl ch2 f3", ROW0 + 4, 4, 49, HLC);
    frames(1);
    check_cell("hl ch2 f4", ROW0 + 4, 4, 49, DIGIT);

    // Two consecutive changes on channel 0 reload the hold
    ch_data[7:0] = 8'h01;
    frames(1);
    ch_data[7:0] = 8'h02;
    frames(1);
    check_cell("reload B", ROW0, 10, 49, HLC);
    frames(1);
    check_cell("reload B+1", ROW0, 10, 49, HLC);
    frames(1);
    check_cell("reload B+2", ROW0, 10, 49, HLC);
    frames(1);
    check_cell("reload B+3", ROW0, 10, 49, DIGIT);

    // Stalled origin yields a single fs
    ch_data[31:24] = 8'h80;
    drive(0, 0, 1'b1);
    drive(0, 0, 1'b1);
    drive(0, 0, 1'b1);
    drive(3, 0, 1'b0);
    check_cell("stall f0", ROW0 + 6, 4, 49, HLC);
    frames(2);
    check_cell("stall f2", ROW0 + 6, 4, 49, HLC);
    frames(1);
    check_cell("stall f3", ROW0 + 6, 4, 49, DIGIT);

    // Valid gating and asynchronous reset mid-line
    hex_mode = 1'b1;
    drive(460, 64, 1'b1);
    drive(460, 64, 1'b1);
    check("pre-reset pixel", 64'(vga_rgb), 64'(DIGIT));
    drive(460, 64, 1'b0);
    drive(460, 64, 1'b0);
    check("valid low", 64'(vga_rgb), 64'(0));
    drive(460, 64, 1'b1);
    drive(460, 64, 1'b1);
    reset_n = 1'b0;
    #1;
    check("async reset", 64'(vga_rgb), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_cell("post-reset c10", ROW0, 10, 48, DIGIT);
    check_cell("post-reset H", ROW0, 1, 8, LABEL);
    frames(1);
    check_cell("after fs hi", ROW0, 4, 48, HLC);
    check_cell("after fs lo", ROW0, 5, 50, HLC);
    check_cell("after fs c6", ROW0, 6, 32, DIGIT);
    check_cell("after fs ch3 hi", ROW0 + 6, 4, 56, HLC);
    check_cell("after fs ch3 lo", ROW0 + 6, 5, 48, HLC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
